// File: rtl/topk_selector_pkg.sv
// Shared types for the vector-DPU result path: score/id widths, top-K list entry and selector state.
package vdpu_pkg;

   localparam int DEFAULT_ID_WIDTH = 20;
   localparam int DEFAULT_SCORE_W  = 32;

   typedef logic signed [DEFAULT_SCORE_W-1:0] score_t;
   typedef logic [DEFAULT_ID_WIDTH-1:0]       vec_id_t;

   typedef struct packed {
      logic    valid;
      score_t  score;
      vec_id_t id;
   } topk_entry_t;

   typedef enum logic {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } topk_state_e;

endpackage

// File: rtl/topk_selector_if.sv
// Score stream in from tensor_core and ready/valid result stream out to the host FIFO.
interface topk_selector_if
   import vdpu_pkg::*;
#(
   parameter int ID_WIDTH = DEFAULT_ID_WIDTH,
   parameter int SCORE_W  = DEFAULT_SCORE_W
) ();

   logic                      valid_in;
   logic signed [SCORE_W-1:0] score_in;
   logic [ID_WIDTH-1:0]       id_in;
   logic                      last_in;
   logic                      in_ready;
   logic                      res_valid;
   logic                      res_ready;
   logic signed [SCORE_W-1:0] res_score;
   logic [ID_WIDTH-1:0]       res_id;
   logic                      res_last;
   logic                      drop_err;

   // Host/upstream side
   modport master (
      output valid_in, score_in, id_in, last_in, res_ready,
      input  in_ready, res_valid, res_score, res_id, res_last, drop_err
   );

   // Selector side
   modport slave (
      input  valid_in, score_in, id_in, last_in, res_ready,
      output in_ready, res_valid, res_score, res_id, res_last, drop_err
   );

endinterface

// File: rtl/topk_selector_cell.sv
// One slot of the sorted top-K list: decides whether to keep, take the new entry,
// take the upper neighbour (pushed down by an insert) or the lower one (drain shift).
module topk_cell
   import vdpu_pkg::*;
#(
   parameter type entry_t = topk_entry_t
) (
   input  entry_t i_own,
   input  entry_t i_upper,
   input  entry_t i_lower,
   input  entry_t i_new,
   input  logic   i_upperIns,
   input  logic   i_doInsert,
   input  logic   i_doShift,
   output entry_t o_next,
   output logic   o_ins
);

   logic w_ins;

   // Strict compare so an equal score never displaces an earlier arrival
   assign w_ins = i_upperIns || !i_own.valid || (i_own.score < i_new.score);
   assign o_ins = w_ins;

   always_comb begin
      o_next = i_own;
      if (i_doShift) begin
         o_next = i_lower;
      end else if (i_doInsert) begin
         if (i_upperIns) begin
            o_next = i_upper;
         end else if (w_ins) begin
            o_next = i_new;
         end
      end
   end

endmodule

// File: rtl/topk_selector.sv
// Streaming top-K selector: insertion-sorts (score, id) beats per query, then drains
// them highest-first over a ready/valid result port.
module topk_selector
   import vdpu_pkg::*;
#(
   parameter int ID_WIDTH = DEFAULT_ID_WIDTH,
   parameter int SCORE_W  = DEFAULT_SCORE_W,
   parameter int K        = 8
) (
   input logic            clk,
   input logic            nrst,
   topk_selector_if.slave bus
);

   typedef struct packed {
      logic                      valid;
      logic signed [SCORE_W-1:0] score;
      logic [ID_WIDTH-1:0]       id;
   } entry_t;

   localparam entry_t EMPTY = '0;

   topk_state_e               r_state;
   entry_t                    r_slot     [K];
   logic                      r_inReady;
   logic                      r_resValid;
   logic                      r_resLast;
   logic                      r_dropErr;
   logic signed [SCORE_W-1:0] r_resScore;
   logic [ID_WIDTH-1:0]       r_resId;

   entry_t                    w_slotExt  [K+2];
   entry_t                    w_next     [K+1];
   logic                      w_insExt   [K+1];
   entry_t                    w_new;
   logic                      w_doInsert;
   logic                      w_doShift;

   assign w_new      = '{valid: 1'b1, score: bus.score_in, id: bus.id_in};
   assign w_doInsert = (r_state == COLLECT) && bus.valid_in;
   assign w_doShift  = (r_state == DRAIN) && r_resValid && bus.res_ready;

   // Empty sentinels at both ends so every cell sees an upper and a lower neighbour
   assign w_slotExt[0]   = EMPTY;
   assign w_slotExt[K+1] = EMPTY;
   assign w_insExt[0]    = 1'b0;
   assign w_next[K]      = EMPTY;

   for (genvar i = 0; i < K; i++) begin : g_cell
      assign w_slotExt[i+1] = r_slot[i];

      topk_cell #(
         .entry_t (entry_t)
      ) u_cell (
         .i_own      (w_slotExt[i+1]),
         .i_upper    (w_slotExt[i]),
         .i_lower    (w_slotExt[i+2]),
         .i_new      (w_new),
         .i_upperIns (w_insExt[i]),
         .i_doInsert (w_doInsert),
         .i_doShift  (w_doShift),
         .o_next     (w_next[i]),
         .o_ins      (w_insExt[i+1])
      );
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state    <= COLLECT;
         for (int i = 0; i < K; i++) begin
            r_slot[i] <= EMPTY;
         end
         r_inReady  <= 1'b1;
         r_resValid <= 1'b0;
         r_resLast  <= 1'b0;
         r_dropErr  <= 1'b0;
         r_resScore <= '0;
         r_resId    <= '0;
      end else begin
         for (int i = 0; i < K; i++) begin
            r_slot[i] <= w_next[i];
         end
         r_dropErr <= bus.valid_in && (r_state != COLLECT);

         case (r_state)
            COLLECT: begin
               if (bus.valid_in && bus.last_in) begin
                  r_state   <= DRAIN;
                  r_inReady <= 1'b0;
               end
            end
            DRAIN: begin
               // Present the head of the list; after a shift the head is the next entry
               if (!r_resValid || bus.res_ready) begin
                  if (r_resValid && r_resLast) begin
                     r_state    <= COLLECT;
                     r_inReady  <= 1'b1;
                     r_resValid <= 1'b0;
                     r_resLast  <= 1'b0;
                  end else begin
                     r_resValid <= 1'b1;
                     r_resScore <= w_next[0].score;
                     r_resId    <= w_next[0].id;
                     r_resLast  <= !w_next[1].valid;
                  end
               end
            end
            default: begin
               r_state <= COLLECT;
            end
         endcase
      end
   end

   assign bus.in_ready  = r_inReady;
   assign bus.res_valid = r_resValid;
   assign bus.res_score = r_resScore;
   assign bus.res_id    = r_resId;
   assign bus.res_last  = r_resLast;
   assign bus.drop_err  = r_dropErr;

endmodule

// File: tb/tb_topk_selector.sv
// Self-checking bench for topk_selector (K=4): directed and random queries compared
// against a stable "pick the highest remaining score" reference model.
module tb_topk_selector;
   import vdpu_pkg::*;

   localparam int K = 4;

   logic clk = 1'b0;
   logic nrst;
   int   checks = 0;
   int   failures = 0;

   score_t  qScore [$];
   vec_id_t qId    [$];
   score_t  expS   [$];
   vec_id_t expI   [$];

   topk_selector_if #(.ID_WIDTH(20), .SCORE_W(32)) bus ();

   topk_selector #(
      .ID_WIDTH (20),
      .SCORE_W  (32),
      .K        (K)
   ) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic addBeat(input score_t s, input vec_id_t i);
      qScore.push_back(s);
      qId.push_back(i);
   endtask

   // Top-K by repeatedly taking the highest remaining score, earliest arrival on ties
   task automatic buildExpected();
      bit used [];
      used = new[qScore.size()];
      expS.delete();
      expI.delete();
      for (int k = 0; k < K; k++) begin
         int best;
         best = -1;
         for (int j = 0; j < qScore.size(); j++) begin
            if (!used[j] && (best < 0 || qScore[j] > qScore[best])) best = j;
         end
         if (best < 0) break;
         used[best] = 1'b1;
         expS.push_back(qScore[best]);
         expI.push_back(qId[best]);
      end
   endtask

   task automatic randomQuery(input int n, input bit narrow);
      qScore.delete();
      qId.delete();
      for (int j = 0; j < n; j++) begin
         if (narrow) addBeat(score_t'(int'($urandom_range(0, 15)) - 8), vec_id_t'($urandom));
         else        addBeat(score_t'(int'($urandom_range(0, 100)) - 50), vec_id_t'($urandom));
      end
   endtask

   task automatic sendQuery();
      checks++;
      if (bus.in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL in_ready_idle: got %b expected 1", bus.in_ready);
      end
      for (int j = 0; j < qScore.size(); j++) begin
         bus.valid_in = 1'b1;
         bus.score_in = qScore[j];
         bus.id_in    = qId[j];
         bus.last_in  = (j == qScore.size() - 1);
         cycle();
      end
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
      buildExpected();
      checks++;
      if (bus.in_ready !== 1'b0 || bus.res_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL after_last: got in_ready=%b res_valid=%b expected 0 0", bus.in_ready, bus.res_valid);
      end
      cycle();
      checks++;
      if (bus.res_valid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL first_beat_latency: got res_valid=%b expected 1", bus.res_valid);
      end
   endtask

   // mode 0: always ready, 1: ready toggles 1010..., 2: random ready
   task automatic drainCheck(input int mode);
      int      b;
      int      guard;
      logic    rdy;
      score_t  heldS;
      vec_id_t heldI;
      b = 0;
      guard = 0;
      while (b < expS.size() && guard < 100) begin
         guard++;
         if (mode == 0)      rdy = 1'b1;
         else if (mode == 1) rdy = guard[0];
         else                rdy = 1'($urandom_range(0, 1));
         checks++;
         if (bus.res_valid !== 1'b1 || bus.res_score !== expS[b] || bus.res_id !== expI[b]) begin
            failures++;
            $display("[TB] FAIL beat%0d: got v=%b score=%0d id=%0d expected v=1 score=%0d id=%0d",
                     b, bus.res_valid, bus.res_score, bus.res_id, expS[b], expI[b]);
         end
         checks++;
         if (bus.res_last !== (b == expS.size() - 1)) begin
            failures++;
            $display("[TB] FAIL res_last%0d: got %b expected %b", b, bus.res_last, (b == expS.size() - 1));
         end
         heldS = bus.res_score;
         heldI = bus.res_id;
         bus.res_ready = rdy;
         cycle();
         bus.res_ready = 1'b0;
         if (rdy) begin
            b++;
         end else begin
            checks++;
            if (bus.res_valid !== 1'b1 || bus.res_score !== heldS || bus.res_id !== heldI) begin
               failures++;
               $display("[TB] FAIL stall_hold: got v=%b score=%0d id=%0d expected v=1 score=%0d id=%0d",
                        bus.res_valid, bus.res_score, bus.res_id, heldS, heldI);
            end
         end
      end
      checks++;
      if (b != expS.size()) begin
         failures++;
         $display("[TB] FAIL handshakes: got %0d expected %0d", b, expS.size());
      end
      checks++;
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL drain_end: got res_valid=%b in_ready=%b expected 0 1", bus.res_valid, bus.in_ready);
      end
   endtask

   task automatic test_reset();
      nrst = 1'b0;
      #12;
      checks++;
      if ({bus.in_ready, bus.res_valid, bus.res_last, bus.drop_err} !== 4'b1000) begin
         failures++;
         $display("[TB] FAIL reset_flags: got %b expected 1000",
                  {bus.in_ready, bus.res_valid, bus.res_last, bus.drop_err});
      end
      checks++;
      if (bus.res_score !== 32'sd0 || bus.res_id !== 20'd0) begin
         failures++;
         $display("[TB] FAIL reset_data: got score=%0d id=%0d expected 0 0", bus.res_score, bus.res_id);
      end
      @(negedge clk);
      nrst = 1'b1;
      cycle();
   endtask

   task automatic test_basic();
      qScore.delete(); qId.delete();
      addBeat(5, 1); addBeat(-3, 2); addBeat(12, 3); addBeat(7, 4); addBeat(0, 5); addBeat(9, 6);
      sendQuery();
      drainCheck(0);
   endtask

   task automatic test_short_query();
      qScore.delete(); qId.delete();
      addBeat(4, 10); addBeat(8, 11);
      sendQuery();
      drainCheck(0);
      qScore.delete(); qId.delete();
      addBeat(-50, 13);
      sendQuery();
      drainCheck(0);
   endtask

   task automatic test_ties();
      qScore.delete(); qId.delete();
      addBeat(7, 20); addBeat(7, 21); addBeat(7, 22);
      sendQuery();
      drainCheck(0);
      qScore.delete(); qId.delete();
      for (int j = 0; j < 5; j++) addBeat(1, vec_id_t'(30 + j));
      sendQuery();
      drainCheck(0);
   endtask

   task automatic test_backpressure();
      randomQuery(6, 1'b0);
      sendQuery();
      drainCheck(1);
      randomQuery(3, 1'b0);
      sendQuery();
      drainCheck(1);
   endtask

   task automatic test_drop();
      randomQuery(5, 1'b0);
      sendQuery();
      bus.valid_in = 1'b1;
      bus.score_in = 100;
      bus.id_in    = 99;
      bus.last_in  = 1'b1;
      cycle();
      bus.valid_in = 1'b0;
      bus.last_in  = 1'b0;
      checks++;
      if (bus.drop_err !== 1'b1) begin
         failures++;
         $display("[TB] FAIL drop_err_pulse: got %b expected 1", bus.drop_err);
      end
      cycle();
      checks++;
      if (bus.drop_err !== 1'b0) begin
         failures++;
         $display("[TB] FAIL drop_err_clear: got %b expected 0", bus.drop_err);
      end
      drainCheck(2);
      randomQuery(6, 1'b0);
      sendQuery();
      drainCheck(0);
   endtask

   task automatic test_extremes();
      qScore.delete(); qId.delete();
      addBeat(32'sh8000_0000, 40); addBeat(-1, 41); addBeat(32'sh7FFF_FFFF, 42);
      sendQuery();
      drainCheck(0);
   endtask

   task automatic test_reset_mid_drain();
      randomQuery(5, 1'b0);
      sendQuery();
      bus.res_ready = 1'b1;
      cycle();
      bus.res_ready = 1'b0;
      #2;
      nrst = 1'b0;
      #1;
      checks++;
      if (bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.res_last !== 1'b0) begin
         failures++;
         $display("[TB] FAIL async_reset: got res_valid=%b in_ready=%b res_last=%b expected 0 1 0",
                  bus.res_valid, bus.in_ready, bus.res_last);
      end
      @(negedge clk);
      nrst = 1'b1;
      cycle();
      checks++;
      if (bus.res_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL aborted_query: got res_valid=%b expected 0", bus.res_valid);
      end
      randomQuery(7, 1'b1);
      sendQuery();
      drainCheck(2);
   endtask

   task automatic test_back_to_back();
      for (int q = 0; q < 25; q++) begin
         randomQuery(int'($urandom_range(1, 7)), q[0]);
         if (q % 5 == 4) qScore[0] = score_t'($urandom);
         sendQuery();
         drainCheck(2);
      end
   endtask

   initial begin
      bus.valid_in  = 1'b0;
      bus.score_in  = '0;
      bus.id_in     = '0;
      bus.last_in   = 1'b0;
      bus.res_ready = 1'b0;
      test_reset();
      test_basic();
      test_short_query();
      test_ties();
      test_backpressure();
      test_drop();
      test_extremes();
      test_reset_mid_drain();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
